// File: rtl/reg_bus_initiator.sv
// Valid/ready command front end that drives a single-strobe register peripheral (en/state/rd_data/wr_data).
// Optional build macro REG_BUS_PUSH_ACK_EN: when defined, pushes also return a response carrying the pushed value.
module reg_bus_initiator #(
   parameter int DATA_WIDTH     = 16,
   parameter int EN_HIGH_CYCLES = 5,
   parameter int EN_LOW_CYCLES  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_dir,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  bus_en,
   output logic                  bus_state,
   output logic [DATA_WIDTH-1:0] bus_rd_data,
   input  logic [DATA_WIDTH-1:0] bus_wr_data,
   output logic                  busy
);

   localparam int CNT_MAX = (EN_HIGH_CYCLES > EN_LOW_CYCLES) ? EN_HIGH_CYCLES : EN_LOW_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(EN_HIGH_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(EN_LOW_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  bus_state_q, bus_state_d;
   logic [DATA_WIDTH-1:0] bus_rd_data_q, bus_rd_data_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         data_q        <= '0;
         bus_state_q   <= 1'b0;
         bus_rd_data_q <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         cmd_ready_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         data_q        <= data_d;
         bus_state_q   <= bus_state_d;
         bus_rd_data_q <= bus_rd_data_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         cmd_ready_q   <= cmd_ready_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      data_d        = data_q;
      bus_state_d   = bus_state_q;
      bus_rd_data_d = bus_rd_data_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      accept        = cmd_valid & cmd_ready_q;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               bus_state_d = cmd_dir;
               data_d      = cmd_data;
               cnt_d       = HIGH_LOAD;
               state_d     = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               cnt_d   = LOW_LOAD;
               state_d = ST_GAP;
               if (bus_state_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = bus_wr_data;
               end else begin
                  bus_rd_data_d = data_q;
`ifdef REG_BUS_PUSH_ACK_EN
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = data_q;
`endif
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Ready is registered from next-state so a pending response blocks acceptance without a comb path from rsp_ready.
      cmd_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign bus_en      = (state_q == ST_STROBE);
   assign bus_state   = bus_state_q;
   assign bus_rd_data = bus_rd_data_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Self-checking bench for reg_bus_initiator: default timing instance plus a 1/1 boundary instance.
module tb_reg_bus_initiator;

`ifdef REG_BUS_PUSH_ACK_EN
   localparam bit ACK = 1'b1;
`else
   localparam bit ACK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_dir = 1'b0;
   logic [15:0] cmd_data = '0;
   logic        rsp_ready = 1'b0;
   logic [15:0] bus_wr_data = '0;

   logic        a_cmd_ready, a_rsp_valid, a_bus_en, a_bus_state, a_busy;
   logic [15:0] a_rsp_data, a_bus_rd_data;
   logic        b_cmd_ready, b_rsp_valid, b_bus_en, b_bus_state, b_busy;
   logic [15:0] b_rsp_data, b_bus_rd_data;

   logic        o_cmd_ready, o_rsp_valid, o_bus_en, o_bus_state, o_busy;
   logic [15:0] o_rsp_data, o_bus_rd_data;

   bit          sel = 1'b0;
   int          total = 0;
   int          bad = 0;
   logic [15:0] m_rd = '0;
   logic [15:0] m_rsp = '0;

   always #5 clk = ~clk;

   reg_bus_initiator #(.DATA_WIDTH(16), .EN_HIGH_CYCLES(5), .EN_LOW_CYCLES(5)) dut_a (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_dir(cmd_dir), .cmd_data(cmd_data),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
      .bus_en(a_bus_en), .bus_state(a_bus_state), .bus_rd_data(a_bus_rd_data),
      .bus_wr_data(bus_wr_data), .busy(a_busy)
   );

   reg_bus_initiator #(.DATA_WIDTH(16), .EN_HIGH_CYCLES(1), .EN_LOW_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_dir(cmd_dir), .cmd_data(cmd_data),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
      .bus_en(b_bus_en), .bus_state(b_bus_state), .bus_rd_data(b_bus_rd_data),
      .bus_wr_data(bus_wr_data), .busy(b_busy)
   );

   assign o_cmd_ready   = sel ? b_cmd_ready   : a_cmd_ready;
   assign o_rsp_valid   = sel ? b_rsp_valid   : a_rsp_valid;
   assign o_rsp_data    = sel ? b_rsp_data    : a_rsp_data;
   assign o_bus_en      = sel ? b_bus_en      : a_bus_en;
   assign o_bus_state   = sel ? b_bus_state   : a_bus_state;
   assign o_bus_rd_data = sel ? b_bus_rd_data : a_bus_rd_data;
   assign o_busy        = sel ? b_busy        : a_busy;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; hold reset three edges, check zeros, release and check readiness.
   task automatic reset_check();
      reset = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("rst_cmd_ready", o_cmd_ready, 1'b0);
         chk1("rst_rsp_valid", o_rsp_valid, 1'b0);
         chk16("rst_rsp_data", o_rsp_data, 16'h0000);
         chk1("rst_bus_en", o_bus_en, 1'b0);
         chk1("rst_bus_state", o_bus_state, 1'b0);
         chk16("rst_bus_rd_data", o_bus_rd_data, 16'h0000);
         chk1("rst_busy", o_busy, 1'b0);
      end
      reset = 1'b0;
      m_rd  = '0;
      m_rsp = '0;
      @(negedge clk);
      chk1("post_rst_cmd_ready", o_cmd_ready, 1'b1);
      chk1("post_rst_busy", o_busy, 1'b0);
   endtask

   // Called at a negedge of a cycle where the DUT should be ready. Accepted at edge T;
   // cycle k is the cycle after edge T+k-1. The peripheral only shows the true value in the
   // last strobe-high cycle so a mistimed sample is caught.
   task automatic run_txn(input logic dir, input logic [15:0] data, input int stall);
      int   h, l, hs, kend;
      logic rg;
      h  = sel ? 1 : 5;
      l  = sel ? 1 : 5;
      rg = dir | ACK;
      hs = h + 1 + stall;
      kend = h + l + 1;
      if (rg && (hs + 1 > kend)) kend = hs + 1;

      chk1("ready_before_cmd", o_cmd_ready, 1'b1);
      cmd_valid   = 1'b1;
      cmd_dir     = dir;
      cmd_data    = data;
      rsp_ready   = 1'b0;
      bus_wr_data = ~data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_dir   = 1'($urandom);
      cmd_data  = 16'($urandom);
      for (int k = 1; k <= kend; k++) begin
         bus_wr_data = (k == h) ? data : ~data;
         rsp_ready   = (k >= hs);
         if (k == h + 1) begin
            if (!dir) m_rd = data;
            if (rg) m_rsp = data;
         end
         @(negedge clk);
         chk1("bus_en", o_bus_en, k <= h);
         chk1("busy", o_busy, k <= h + l);
         chk1("bus_state", o_bus_state, dir);
         chk16("bus_rd_data", o_bus_rd_data, m_rd);
         chk1("rsp_valid", o_rsp_valid, rg && (k >= h + 1) && (k <= hs));
         chk16("rsp_data", o_rsp_data, m_rsp);
         chk1("cmd_ready", o_cmd_ready, k == kend);
         if (k < kend) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      sel = 1'b0;
      @(negedge clk);
      reset_check();

      run_txn(1'b0, 16'h1234, 0);
      run_txn(1'b1, 16'hBEEF, 0);
      run_txn(1'b1, 16'h5C3A, 20);
      run_txn(1'b0, 16'hA5A5, 0);
      run_txn(1'b0, 16'h0F0F, 3);

      // Reset in the middle of a strobe: nothing of the push may survive.
      cmd_valid = 1'b1;
      cmd_dir   = 1'b0;
      cmd_data  = 16'h7E57;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk1("mid_strobe_en", o_bus_en, 1'b1);
      @(negedge clk);
      reset_check();
      chk16("mid_rst_rd_data", o_bus_rd_data, 16'h0000);

      for (int n = 0; n < 12; n++) begin
         run_txn(1'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      end

      sel = 1'b1;
      reset_check();
      for (int n = 0; n < 6; n++) begin
         run_txn(1'b0, 16'h0000, 0);
         run_txn(1'b1, 16'hFFFF, 0);
      end
      for (int n = 0; n < 10; n++) begin
         run_txn(1'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
